cu_tree_walker: RTL and testbench
=================================

# cu_tree_walker

Downstream reader of the 85-entry, 6-bit per-node LCU quadtree buffer (node order: depth 0 at index 0, depth 1 at 1..4, depth 2 at 5..20, depth 3 at 21..84). On a start pulse it walks one 64x64 LCU quadtree depth-first in z-order and emits one record per leaf CU (depth, position, 5-bit info) on a valid/ready stream. Its output feeds the coefficient/CABAC stage. The buffer is written by the upstream mode-decision stage before `start_i`.

## Interface
Parameters:
- `NODE_AW`, 10, buffer address width
- `INFO_W`, 5, payload width (entry = {split, info}, 6 bits)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `start_i`  in  1  begin walk; sampled only in IDLE
- `busy_o`  out  1  high from the cycle after start is accepted until `done_o`, inclusive
- `done_o`  out  1  one-cycle pulse, walk finished
- `ram_ce_o`  out  1  buffer chip enable (read strobe)
- `ram_we_o`  out  1  tied 0
- `ram_addr_o`  out  NODE_AW  node index
- `ram_data_i`  in  6  buffer read data, valid the cycle after `ram_ce_o`
- `cu_valid_o`  out  1  leaf record valid
- `cu_ready_i`  in  1  consumer accepts
- `cu_depth_o`  out  2  leaf depth 0..3 (64,32,16,8)
- `cu_x_o`, `cu_y_o`  out  3 each  leaf top-left in 8x8 units
- `cu_info_o`  out  INFO_W  `ram_data_i[4:0]` of the leaf node

## Operation
- Entry bit 5 = split flag; bits 4:0 = info. Split ignored at depth 3 (always a leaf).
- Path registers `c1,c2,c3` (2 bits each) plus depth `d`. Z-index at depth d = {c1..cd}. Address = base(d) + z, with base = 0,1,5,21, zero-extended to NODE_AW.
- Position: x = {c1[0],c2[0],c3[0]}, y = {c1[1],c2[1],c3[1]}, with path levels deeper than d forced to 0.
- FSM:
  - IDLE: if `start_i`: d=0, path=0, go to RD.
  - RD: `ram_ce_o`=1, addr driven; go to CHK.
  - CHK: sample `ram_data_i`.
    - If split and d<3: d++, new level c=0, go to RD.
    - Otherwise latch info, go to EMIT.
  - EMIT: `cu_valid_o`=1, outputs stable; on `cu_ready_i` go to ADV.
  - ADV: one cycle per evaluated level.
    - If d==0: go to DONE.
    - Else if c_d<3: c_d++, go to RD.
    - Else clear c_d, d--, stay in ADV.
  - DONE: `done_o`=1 for one cycle, go to IDLE.
- Info of split nodes is never emitted. Leaves are emitted in strict z-order.
- `start_i` outside IDLE is ignored.

## Timing
- Reset values: state IDLE, all outputs 0 (`busy_o`, `done_o`, `ram_ce_o`, `ram_addr_o`, `cu_valid_o`, depth, x, y, info). Path and depth are cleared.
- Reset mid-walk aborts immediately: no `done_o`, `cu_valid_o` drops the next cycle.
- Start sampled at edge k:
  - RD in cycle k+1.
  - CHK in k+2 (RAM latency 1).
  - First leaf at depth 0 is valid in k+3.
- Descending one level costs 2 cycles (RD, CHK).
- Per leaf: RD, CHK, EMIT (≥1 cycle), ADV (1 cycle plus 1 per popped level).
- `cu_valid_o` stays high with stable fields until accepted. It never deasserts without `cu_ready_i`.
- `ram_ce_o` is high only in RD. `ram_addr_o` holds its value outside RD.
- `done_o` is asserted in the cycle after the final ADV. IDLE is re-entered on the following cycle and can accept `start_i` then.

## Structure
- Shared package (enc_defines):
  - `NODE_NUM`=85, `MAX_DEPTH`=3
  - depth bases 0/1/5/21
  - field positions `SPLIT_BIT`=5, `INFO_LSB`=0
  - FSM state encodings
- Optional sub-module `cu_tree_addr`: combinational (d, c1..c3) → address, x, y. Everything else stays in one module.

## Test plan
- Root entry 6'b0_01010, `cu_ready_i`=1: exactly one record, depth 0, x=y=0, info 0x0A; valid at start+3; `done_o` at start+5.
- All nodes at depth < 3 have split=1, leaves info = index[4:0], ready=1: 64 records at depth 3, x/y in z-order (0,0),(1,0),(0,1),(1,1),(2,0)…; last is (7,7); addresses 21..84 read exactly once.
- Root split, node 2 split, others leaf: 7 records in order d1(0,0), d2(4,0),(6,0),(4,2),(6,2), d1(0,4), d1(4,4).
- Random `cu_ready_i` backpressure on the full-split tree: no record dropped or duplicated; fields stable while valid && !ready.
- `start_i` pulsed while busy: ignored, record count unchanged. `rst` asserted after 10 leaves: outputs 0 next cycle, no `done_o`; a fresh start then walks the full tree.

Source files
------------

// File: rtl/cu_tree_walker_pkg.sv
// ============================================================================
//  Module   : cu_tree_walker_pkg
//  Brief    : Shared constants, depth-base lookup and FSM encoding for the
//             LCU quadtree walker.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cu_tree_walker_pkg;

  localparam int NODE_NUM   = 85;
  localparam int NODE_IDX_W = $clog2(NODE_NUM);
  localparam int MAX_DEPTH  = 3;
  localparam int SPLIT_BIT  = 5;
  localparam int INFO_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CHK  = 3'd2,
    ST_EMIT = 3'd3,
    ST_ADV  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // First node index of each depth in the flattened 85-entry buffer.
  function automatic logic [NODE_IDX_W-1:0] depth_base(input logic [1:0] depth);
    case (depth)
      2'd0:    depth_base = NODE_IDX_W'(0);
      2'd1:    depth_base = NODE_IDX_W'(1);
      2'd2:    depth_base = NODE_IDX_W'(5);
      default: depth_base = NODE_IDX_W'(21);
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cu_tree_walker_if.sv
// ============================================================================
//  Module   : cu_tree_walker_if
//  Brief    : Control, node-buffer read port and leaf-CU stream of the walker.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cu_tree_walker_if #(
  parameter int NODE_AW = 10,
  parameter int INFO_W  = 5
) ();

  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic               ram_ce_o;
  logic               ram_we_o;
  logic [NODE_AW-1:0] ram_addr_o;
  logic [INFO_W:0]    ram_data_i;
  logic               cu_valid_o;
  logic               cu_ready_i;
  logic [1:0]         cu_depth_o;
  logic [2:0]         cu_x_o;
  logic [2:0]         cu_y_o;
  logic [INFO_W-1:0]  cu_info_o;

  modport master (
    input  start_i, ram_data_i, cu_ready_i,
    output busy_o, done_o, ram_ce_o, ram_we_o, ram_addr_o,
    output cu_valid_o, cu_depth_o, cu_x_o, cu_y_o, cu_info_o
  );

  modport slave (
    output start_i, ram_data_i, cu_ready_i,
    input  busy_o, done_o, ram_ce_o, ram_we_o, ram_addr_o,
    input  cu_valid_o, cu_depth_o, cu_x_o, cu_y_o, cu_info_o
  );

endinterface

`default_nettype wire

// File: rtl/cu_tree_walker_addr.sv
// ============================================================================
//  Module   : cu_tree_walker_addr
//  Brief    : Maps (depth, path) to buffer node index and 8x8-unit position.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_tree_walker_addr
  import cu_tree_walker_pkg::*;
#(
  parameter int NODE_AW = 10
) (
  input  logic [1:0]         depth,
  input  logic [2:0][1:0]    path,
  output logic [NODE_AW-1:0] node_idx,
  output logic [2:0]         pos_x,
  output logic [2:0]         pos_y
);

  logic [2:0]            w_lvl_en;
  logic [5:0]            w_z;
  logic [NODE_IDX_W-1:0] w_sum;

  // Levels below the current depth are masked so stale path bits never leak.
  always_comb begin
    w_lvl_en = 3'b000;
    w_z      = '0;
    case (depth)
      2'd0: begin end
      2'd1: begin
        w_lvl_en = 3'b001;
        w_z      = {4'b0000, path[0]};
      end
      2'd2: begin
        w_lvl_en = 3'b011;
        w_z      = {2'b00, path[0], path[1]};
      end
      default: begin
        w_lvl_en = 3'b111;
        w_z      = {path[0], path[1], path[2]};
      end
    endcase
    w_sum    = depth_base(depth) + NODE_IDX_W'(w_z);
    node_idx = NODE_AW'(w_sum);
    pos_x    = {path[0][0] & w_lvl_en[0], path[1][0] & w_lvl_en[1], path[2][0] & w_lvl_en[2]};
    pos_y    = {path[0][1] & w_lvl_en[0], path[1][1] & w_lvl_en[1], path[2][1] & w_lvl_en[2]};
  end

endmodule

`default_nettype wire

// File: rtl/cu_tree_walker.sv
// ============================================================================
//  Module   : cu_tree_walker
//  Brief    : Depth-first z-order walk of one 64x64 LCU quadtree, emitting
//             one record per leaf CU on a valid/ready stream.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_tree_walker
  import cu_tree_walker_pkg::*;
#(
  parameter int NODE_AW = 10,
  parameter int INFO_W  = 5
) (
  input  logic            clk,
  input  logic            rst,
  cu_tree_walker_if.master bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_depth;
  logic [1:0]         w_depth_nxt;
  logic [2:0][1:0]    r_path;
  logic [2:0][1:0]    w_path_nxt;
  logic [1:0]         w_lvl;
  logic               w_load;
  logic [NODE_AW-1:0] w_addr_nxt;
  logic [NODE_AW-1:0] r_addr;
  logic [2:0]         w_x;
  logic [2:0]         w_y;
  logic [1:0]         r_cu_depth;
  logic [2:0]         r_cu_x;
  logic [2:0]         r_cu_y;
  logic [INFO_W-1:0]  r_cu_info;

  // Address/position are derived from the next path so the read address can
  // be registered on entry to RD and then held until the next read.
  cu_tree_walker_addr #(
    .NODE_AW (NODE_AW)
  ) u_addr (
    .depth    (w_depth_nxt),
    .path     (w_path_nxt),
    .node_idx (w_addr_nxt),
    .pos_x    (w_x),
    .pos_y    (w_y)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    w_path_nxt  = r_path;
    w_load      = 1'b0;
    w_lvl       = r_depth - 2'd1;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          w_depth_nxt = '0;
          w_path_nxt  = '0;
          w_state_nxt = ST_RD;
        end
      end
      ST_RD: w_state_nxt = ST_CHK;
      ST_CHK: begin
        if (bus.ram_data_i[SPLIT_BIT] && (r_depth != 2'(MAX_DEPTH))) begin
          w_depth_nxt         = r_depth + 2'd1;
          w_path_nxt[r_depth] = 2'd0;
          w_state_nxt         = ST_RD;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (bus.cu_ready_i) w_state_nxt = ST_ADV;
      end
      ST_ADV: begin
        if (r_depth == 2'd0) begin
          w_state_nxt = ST_DONE;
        end else if (r_path[w_lvl] != 2'd3) begin
          w_path_nxt[w_lvl] = r_path[w_lvl] + 2'd1;
          w_state_nxt       = ST_RD;
        end else begin
          // Last sibling consumed: pop one level and re-evaluate next cycle.
          w_path_nxt[w_lvl] = 2'd0;
          w_depth_nxt       = r_depth - 2'd1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_depth    <= '0;
      r_path     <= '0;
      r_addr     <= '0;
      r_cu_depth <= '0;
      r_cu_x     <= '0;
      r_cu_y     <= '0;
      r_cu_info  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_depth <= w_depth_nxt;
      r_path  <= w_path_nxt;
      if (w_state_nxt == ST_RD) r_addr <= w_addr_nxt;
      if (w_load) begin
        r_cu_depth <= r_depth;
        r_cu_x     <= w_x;
        r_cu_y     <= w_y;
        r_cu_info  <= bus.ram_data_i[INFO_LSB +: INFO_W];
      end
    end
  end

  assign bus.busy_o     = (r_state != ST_IDLE);
  assign bus.done_o     = (r_state == ST_DONE);
  assign bus.ram_ce_o   = (r_state == ST_RD);
  assign bus.ram_we_o   = 1'b0;
  assign bus.ram_addr_o = r_addr;
  assign bus.cu_valid_o = (r_state == ST_EMIT);
  assign bus.cu_depth_o = r_cu_depth;
  assign bus.cu_x_o     = r_cu_x;
  assign bus.cu_y_o     = r_cu_y;
  assign bus.cu_info_o  = r_cu_info;

endmodule

`default_nettype wire

// File: tb/tb_cu_tree_walker.sv
// ============================================================================
//  Module   : tb_cu_tree_walker
//  Brief    : Self-checking bench for cu_tree_walker with a node-buffer model
//             and a cell-by-cell quadtree reference.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cu_tree_walker;

  localparam int BUDGET = 4000;

  typedef struct packed {
    logic [1:0] d;
    logic [2:0] x;
    logic [2:0] y;
    logic [4:0] info;
  } rec_t;

  typedef struct {
    logic [84:0] split;
    bit          rand_ready;
    int          n_rec;
    logic [1:0]  last_d;
    logic [2:0]  last_x;
    logic [2:0]  last_y;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cu_tree_walker_if #(.NODE_AW(10), .INFO_W(5)) bus ();

  cu_tree_walker #(.NODE_AW(10), .INFO_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [5:0] mem [0:84];
  int         rd_cnt [0:84];
  int         bad_addr = 0;

  always @(posedge clk) begin
    if (bus.ram_ce_o) begin
      if (bus.ram_addr_o < 10'd85) begin
        bus.ram_data_i <= mem[bus.ram_addr_o];
        rd_cnt[bus.ram_addr_o] <= rd_cnt[bus.ram_addr_o] + 1;
      end else begin
        bus.ram_data_i <= 6'h3F;
        bad_addr <= bad_addr + 1;
      end
    end
  end

  int   total = 0;
  int   bad   = 0;
  rec_t got_q [$];
  rec_t exp_q [$];
  bit   visit [0:84];
  int   snap  [0:84];
  int   snap_bad;
  int   done_cnt;
  bit   timeout;
  bit   aborted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int base_of(input int d);
    return ((1 << (2 * d)) - 1) / 3;
  endfunction

  // Reference: for every 8x8 cell in z-order find its enclosing leaf; a leaf
  // is emitted when the cell is its top-left one.
  task automatic build_model();
    exp_q.delete();
    for (int i = 0; i < 85; i++) visit[i] = 1'b0;
    for (int z = 0; z < 64; z++) begin
      int         d;
      int         idx;
      bit         stop;
      logic [5:0] zb;
      rec_t       r;
      d    = 0;
      idx  = 0;
      stop = 1'b0;
      zb   = 6'(z);
      while (!stop) begin
        idx = base_of(d) + (z >> (2 * (3 - d)));
        visit[idx] = 1'b1;
        if (mem[idx][5] && d < 3) d++;
        else stop = 1'b1;
      end
      if (z % (1 << (2 * (3 - d))) == 0) begin
        r.d    = 2'(d);
        r.x    = {zb[4], zb[2], zb[0]};
        r.y    = {zb[5], zb[3], zb[1]};
        r.info = mem[idx][4:0];
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic run_walk(input bit rand_ready, input int poke_at, input int abort_after);
    int   cyc;
    int   nhs;
    bit   prev_stall;
    rec_t prev;
    rec_t cur;
    got_q.delete();
    done_cnt = 0;
    timeout  = 1'b0;
    aborted  = 1'b0;
    snap_bad = bad_addr;
    for (int i = 0; i < 85; i++) snap[i] = rd_cnt[i];
    cyc        = 0;
    nhs        = 0;
    prev_stall = 1'b0;
    prev       = '0;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    while (1) begin
      cur = {bus.cu_depth_o, bus.cu_x_o, bus.cu_y_o, bus.cu_info_o};
      if (prev_stall) check("hold", {19'd0, bus.cu_valid_o, cur}, {19'd0, 1'b1, prev});
      if (bus.done_o) begin
        done_cnt++;
        break;
      end
      bus.start_i    = (cyc == poke_at);
      bus.cu_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall     = bus.cu_valid_o && !bus.cu_ready_i;
      prev           = cur;
      if (bus.cu_valid_o && bus.cu_ready_i) begin
        got_q.push_back(cur);
        nhs++;
        if (nhs == abort_after) begin
          aborted = 1'b1;
          break;
        end
      end
      cyc++;
      if (cyc > BUDGET) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.start_i = 1'b0;
    check("walk_timeout", 32'(timeout), 32'd0);
  endtask

  task automatic compare_walk(input string tag);
    int n;
    int badr;
    build_model();
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_rec%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    badr = bad_addr - snap_bad;
    for (int i = 0; i < 85; i++)
      if (rd_cnt[i] - snap[i] != int'(visit[i])) badr++;
    check({tag, "_reads"}, 32'(badr), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {30'd0, bus.done_o, bus.busy_o}, 32'd0);
  endtask

  vec_t vt [7];

  initial begin
    int dseen;
    vt[0] = '{85'h0,          1'b0, 1,  2'd0, 3'd0, 3'd0};
    vt[1] = '{85'h1FFFFF,     1'b0, 64, 2'd3, 3'd7, 3'd7};
    vt[2] = '{85'h5,          1'b0, 7,  2'd1, 3'd4, 3'd4};
    vt[3] = '{85'h1,          1'b0, 4,  2'd1, 3'd4, 3'd4};
    vt[4] = '{{85{1'b1}},     1'b1, 64, 2'd3, 3'd7, 3'd7};
    vt[5] = '{85'h23,         1'b0, 10, 2'd1, 3'd4, 3'd4};
    vt[6] = '{85'h100011,     1'b1, 10, 2'd3, 3'd7, 3'd7};

    bus.start_i    = 1'b0;
    bus.cu_ready_i = 1'b0;
    for (int i = 0; i < 85; i++) mem[i] = 6'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {27'd0, bus.busy_o, bus.done_o, bus.ram_ce_o, bus.ram_we_o, bus.cu_valid_o}, 32'd0);
    check("reset_fields", {9'd0, bus.ram_addr_o, bus.cu_depth_o, bus.cu_x_o, bus.cu_y_o, bus.cu_info_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-leaf root: exact cycle timing from the start edge.
    mem[0] = 6'b0_01010;
    bus.cu_ready_i = 1'b1;
    bus.start_i    = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check("t1_rd", {28'd0, bus.busy_o, bus.ram_ce_o, bus.cu_valid_o, 1'b0}, {28'd0, 4'b1100});
    check("t1_rd_addr", 32'(bus.ram_addr_o), 32'd0);
    @(posedge clk); #1;
    check("t2_chk", {30'd0, bus.ram_ce_o, bus.cu_valid_o}, 32'd0);
    @(posedge clk); #1;
    check("t3_emit", {18'd0, bus.cu_valid_o, bus.cu_depth_o, bus.cu_x_o, bus.cu_y_o, bus.cu_info_o},
          {18'd0, 1'b1, 2'd0, 3'd0, 3'd0, 5'h0A});
    @(posedge clk); #1;
    check("t4_adv", {30'd0, bus.cu_valid_o, bus.done_o}, 32'd0);
    @(posedge clk); #1;
    check("t5_done", {30'd0, bus.done_o, bus.busy_o}, 32'd3);
    @(posedge clk); #1;
    check("t6_idle", {30'd0, bus.done_o, bus.busy_o}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 85; i++) mem[i] = {vt[v].split[i], 5'(i)};
      run_walk(vt[v].rand_ready, -1, -1);
      check($sformatf("vec%0d_n", v), 32'(got_q.size()), 32'(vt[v].n_rec));
      if (got_q.size() > 0)
        check($sformatf("vec%0d_last", v),
              {24'd0, got_q[got_q.size()-1].d, got_q[got_q.size()-1].x, got_q[got_q.size()-1].y},
              {24'd0, vt[v].last_d, vt[v].last_x, vt[v].last_y});
      compare_walk($sformatf("vec%0d", v));
    end

    // Start pulsed while busy must be ignored.
    for (int i = 0; i < 85; i++) mem[i] = {(i < 21), 5'(i)};
    run_walk(1'b0, 30, -1);
    compare_walk("poke");

    // Reset after ten leaves aborts the walk silently.
    run_walk(1'b0, -1, 10);
    check("abort_taken", 32'(aborted), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ctrl", {28'd0, bus.busy_o, bus.done_o, bus.ram_ce_o, bus.cu_valid_o}, 32'd0);
    check("abort_fields", {9'd0, bus.ram_addr_o, bus.cu_depth_o, bus.cu_x_o, bus.cu_y_o, bus.cu_info_o}, 32'd0);
    rst   = 1'b0;
    dseen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done_o || bus.busy_o) dseen++;
    end
    check("abort_no_done", 32'(dseen), 32'd0);
    run_walk(1'b1, -1, -1);
    compare_walk("restart");

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 85; i++) mem[i] = 6'($urandom);
      run_walk(1'b1, -1, -1);
      compare_walk($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
